// File: rtl/edge_ctrl_pkg.sv
// Shared types and helpers for the edge-detection frame sequencer.
package edge_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  typedef enum logic [1:0] {
    CH_NONE,
    CH_RD,
    CH_WR
  } ch_t;

  localparam int NPIX = 64 * 64;

  function automatic int cnt_w(input int npix);
    return $clog2(npix + 1);
  endfunction

endpackage

// File: rtl/edge_bus_arbiter.sv
// Shares one Avalon-MM master between the read and write channels,
// write first, holding a granted transfer until WAITREQUEST drops.
module edge_bus_arbiter
  import edge_ctrl_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_rd_req,
  input  logic [AW-1:0] i_rd_addr,
  input  logic          i_wr_req,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_waitreq,
  output logic          o_read,
  output logic          o_write,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_wdata,
  output logic          o_rd_done,
  output logic          o_wr_done
);

  ch_t r_ch;
  ch_t w_ch;

  // A stalled grant is remembered; otherwise re-arbitrate every cycle.
  always_comb begin
    w_ch = r_ch;
    if (r_ch == CH_NONE) begin
      if (i_wr_req)
        w_ch = CH_WR;
      else if (i_rd_req)
        w_ch = CH_RD;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_ch <= CH_NONE;
    else if ((w_ch != CH_NONE) && i_waitreq)
      r_ch <= w_ch;
    else
      r_ch <= CH_NONE;
  end

  assign o_read    = (w_ch == CH_RD);
  assign o_write   = (w_ch == CH_WR);
  assign o_addr    = o_write ? i_wr_addr :
                     o_read  ? i_rd_addr : '0;
  assign o_wdata   = o_write ? i_wr_data : '0;
  assign o_rd_done = o_read & ~i_waitreq;
  assign o_wr_done = o_write & ~i_waitreq;

endmodule

// File: rtl/edge_frame_sequencer.sv
// Streams one frame from memory through the edge core and back,
// sharing a single Avalon-MM master between both directions.
module edge_frame_sequencer
  import edge_ctrl_pkg::*;
#(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  CSI_CLOCK_CLK,
  input  logic                  CSI_CLOCK_RESET,
  input  logic                  go,
  output logic                  done,
  output logic                  busy,
  input  logic [15:0]           inputAdd_offset,
  input  logic [15:0]           outputAdd_offset,
  output logic [ADDR_WIDTH-1:0] AVM_AVALONMASTER_ADDRESS,
  output logic                  AVM_AVALONMASTER_READ,
  output logic                  AVM_AVALONMASTER_WRITE,
  output logic [DATA_WIDTH-1:0] AVM_AVALONMASTER_WRITEDATA,
  input  logic [DATA_WIDTH-1:0] AVM_AVALONMASTER_READDATA,
  input  logic                  AVM_AVALONMASTER_WAITREQUEST,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  input  logic [DATA_WIDTH-1:0] res_data,
  input  logic                  res_valid,
  output logic                  res_ready
);

  localparam int NP = IMG_WIDTH * IMG_HEIGHT;
  localparam int CW = cnt_w(NP);
  localparam logic [CW-1:0] NP_C = CW'(NP);

  state_t r_state;
  state_t w_next;

  logic                  r_go_q;
  logic [ADDR_WIDTH-1:0] r_in_base;
  logic [ADDR_WIDTH-1:0] r_out_base;
  logic [CW-1:0]         r_rd_cnt;
  logic [CW-1:0]         r_wr_cnt;
  logic [CW-1:0]         r_res_cnt;
  logic [DATA_WIDTH-1:0] r_pix;
  logic [DATA_WIDTH-1:0] r_res;
  logic                  r_pix_full;
  logic                  r_res_full;

  logic                  w_start;
  logic                  w_run;
  logic                  w_rd_req;
  logic                  w_wr_req;
  logic                  w_rd_done;
  logic                  w_wr_done;
  logic                  w_res_take;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [ADDR_WIDTH-1:0] w_wr_addr;

  assign w_start = go & ~r_go_q & (r_state == IDLE);

  always_comb begin
    w_next = r_state;
    done   = 1'b0;
    busy   = 1'b0;
    w_run  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start)
          w_next = RUN;
      end
      RUN: begin
        busy  = 1'b1;
        w_run = 1'b1;
        if (r_wr_cnt == NP_C)
          w_next = FINISH;
      end
      FINISH: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CSI_CLOCK_CLK) begin
    if (CSI_CLOCK_RESET)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  assign w_rd_req   = w_run & ~r_pix_full & (r_rd_cnt < NP_C);
  assign w_wr_req   = w_run & r_res_full;
  assign res_ready  = w_run & ~r_res_full & (r_res_cnt < NP_C);
  assign w_res_take = res_valid & res_ready;
  assign w_rd_addr  = r_in_base + ADDR_WIDTH'(r_rd_cnt);
  assign w_wr_addr  = r_out_base + ADDR_WIDTH'(r_wr_cnt);
  assign pix_data   = r_pix;
  assign pix_valid  = r_pix_full;

  always_ff @(posedge CSI_CLOCK_CLK) begin
    if (CSI_CLOCK_RESET) begin
      r_go_q     <= 1'b0;
      r_in_base  <= '0;
      r_out_base <= '0;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
      r_res_cnt  <= '0;
      r_pix      <= '0;
      r_res      <= '0;
      r_pix_full <= 1'b0;
      r_res_full <= 1'b0;
    end else begin
      r_go_q <= go;
      if (w_start) begin
        r_in_base  <= ADDR_WIDTH'(inputAdd_offset);
        r_out_base <= ADDR_WIDTH'(outputAdd_offset);
        r_rd_cnt   <= '0;
        r_wr_cnt   <= '0;
        r_res_cnt  <= '0;
        r_pix_full <= 1'b0;
        r_res_full <= 1'b0;
      end else begin
        // A drain cycle never overlaps a read: the read needs an empty register.
        if (w_rd_done) begin
          r_pix      <= AVM_AVALONMASTER_READDATA;
          r_pix_full <= 1'b1;
          if (r_rd_cnt < NP_C)
            r_rd_cnt <= r_rd_cnt + 1'b1;
        end else if (r_pix_full && pix_ready) begin
          r_pix_full <= 1'b0;
        end
        if (w_res_take) begin
          r_res      <= res_data;
          r_res_full <= 1'b1;
          if (r_res_cnt < NP_C)
            r_res_cnt <= r_res_cnt + 1'b1;
        end else if (w_wr_done) begin
          r_res_full <= 1'b0;
          if (r_wr_cnt < NP_C)
            r_wr_cnt <= r_wr_cnt + 1'b1;
        end
      end
    end
  end

  edge_bus_arbiter #(
    .AW(ADDR_WIDTH),
    .DW(DATA_WIDTH)
  ) u_arb (
    .i_clk     (CSI_CLOCK_CLK),
    .i_rst     (CSI_CLOCK_RESET),
    .i_rd_req  (w_rd_req),
    .i_rd_addr (w_rd_addr),
    .i_wr_req  (w_wr_req),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (r_res),
    .i_waitreq (AVM_AVALONMASTER_WAITREQUEST),
    .o_read    (AVM_AVALONMASTER_READ),
    .o_write   (AVM_AVALONMASTER_WRITE),
    .o_addr    (AVM_AVALONMASTER_ADDRESS),
    .o_wdata   (AVM_AVALONMASTER_WRITEDATA),
    .o_rd_done (w_rd_done),
    .o_wr_done (w_wr_done)
  );

endmodule

// File: doc/edge_frame_sequencer.md
Name: edge_frame_sequencer

Overview:
Sequences one edge-detection frame after the control slave raises go. It streams input pixels from memory (inputAdd_offset base) into the edge-detection core and writes the core's results back to memory (outputAdd_offset base). It shares a single Avalon-MM master port between the read channel and the write channel. It pulses done when the last result word has been written, and the slave turns that pulse into its sticky status bit.

Parameters:
IMG_WIDTH, 64, pixels per line
IMG_HEIGHT, 64, lines per frame; NPIX = IMG_WIDTH*IMG_HEIGHT
ADDR_WIDTH, 16, master word-address width
DATA_WIDTH, 16, bus/pixel word width

Ports:
CSI_CLOCK_CLK  in  1  sole clock; all logic on rising edge
CSI_CLOCK_RESET  in  1  reset, synchronous, active-high
go  in  1  start level from control slave
done  out  1  one-cycle completion pulse to control slave
busy  out  1  high from start until done pulse inclusive
inputAdd_offset  in  16  input frame base word address
outputAdd_offset  in  16  output frame base word address
AVM_AVALONMASTER_ADDRESS  out  ADDR_WIDTH  word address
AVM_AVALONMASTER_READ  out  1  read strobe
AVM_AVALONMASTER_WRITE  out  1  write strobe
AVM_AVALONMASTER_WRITEDATA  out  DATA_WIDTH  write data
AVM_AVALONMASTER_READDATA  in  DATA_WIDTH  read data, valid when READ=1 and WAITREQUEST=0
AVM_AVALONMASTER_WAITREQUEST  in  1  slave stall
pix_data  out  DATA_WIDTH  pixel to core
pix_valid  out  1  pixel holding register full
pix_ready  in  1  core accepts pixel
res_data  in  DATA_WIDTH  result from core
res_valid  in  1  core result present
res_ready  out  1  result holding register empty and results still owed

Behaviour:
- Reset: on a clock edge with CSI_CLOCK_RESET=1, go to IDLE. done, busy, READ, WRITE, pix_valid and res_ready are 0. ADDRESS and WRITEDATA are 0. Counters and holding registers are cleared. A reset mid-frame aborts the frame with no done pulse.
- FSM states: IDLE, RUN, FINISH.
  - IDLE->RUN on a rising edge of go (go=1 while the registered go_q=0). On that edge, latch both base addresses, clear rd_cnt and wr_cnt, set busy.
  - RUN->FINISH when wr_cnt reaches NPIX.
  - FINISH->IDLE after exactly one cycle. done=1 only in FINISH. busy drops in the following IDLE cycle.
- go edges during RUN or FINISH are ignored. go falling mid-frame does not abort.
- Read channel:
  - Eligible when rd_cnt<NPIX and the pixel register is empty.
  - Address = in_base + rd_cnt, truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH).
  - On the READ & !WAITREQUEST cycle: capture READDATA into the pixel register, set pix_valid next cycle, increment rd_cnt.
- Pixel hand-off: a transfer occurs when pix_valid & pix_ready. The register empties next cycle. No read is issued in the same cycle as the drain, so the read-to-read spacing is at least 2 cycles.
- Result capture:
  - res_ready=1 when the result register is empty and results accepted < NPIX.
  - On res_valid & res_ready, load the result register.
  - Results beyond NPIX are never accepted.
- Write channel:
  - Eligible when the result register is full.
  - Address = out_base + wr_cnt, truncated.
  - WRITEDATA = result register.
  - On WRITE & !WAITREQUEST: empty the register and increment wr_cnt.
- Arbitration:
  - Decided only when no transaction is in flight.
  - Write has priority over read when both are eligible. This prevents deadlock when the core stalls on a full output.
  - Once asserted, READ or WRITE is held with a stable ADDRESS and WRITEDATA until WAITREQUEST=0.
  - READ and WRITE are never both 1.
  - The next arbitration happens in the cycle after completion.
- Zero-wait-state slave: one transfer completes per 2 cycles per channel.
- Counters are $clog2(NPIX+1) bits wide and saturate at NPIX.

Decomposition:
- Package edge_ctrl_pkg holds:
  - state enum (IDLE/RUN/FINISH)
  - NPIX
  - counter width function
  - channel-select encoding (CH_NONE/CH_RD/CH_WR)
- Sub-module edge_bus_arbiter: write-priority grant plus transaction hold on WAITREQUEST. It drives the master strobes, address and writedata from the two channel request/address/data inputs and returns per-channel completion pulses.
- The top level contains the FSM, counters and holding registers.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=2, in_base=0x0100, out_base=0x0200, zero-wait memory, core = identity with 1-cycle latency, go 0->1 -> reads 0x0100..0x0107 and writes 0x0200..0x0207 with matching data; exactly one done pulse; busy low afterwards.
- Same setup, WAITREQUEST held 3 cycles on every transfer -> ADDRESS, WRITEDATA and strobes are stable while stalled; same final memory image; one done pulse.
- Core holds pix_ready=0 for 20 cycles after the first pixel -> only 1 read issued (pixel register full); no further reads; resumes correctly.
- Both channels eligible in the same cycle (result register full, pixel register empty) -> WRITE granted first, READ granted on the next arbitration.
- in_base=0xFFFE, 8 pixels -> read addresses 0xFFFE, 0xFFFF, 0x0000..0x0005 (wrap).
- Reset asserted mid-frame after 3 writes, then go re-pulsed -> no done from the aborted frame; the new frame restarts at base with rd_cnt=wr_cnt=0. Also, go toggled during RUN -> ignored.
